// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// The state enum is binary encoded; WIDTH_DEFAULT sizes the default build.
package serial_adder_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_fulladder.sv
// One-bit full-adder cell used as the serial adder's bit slice.
// A is the sum bit, cout the carry out.
module fulladder (
   input  logic x,
   input  logic y,
   input  logic cin,
   output logic A,
   output logic cout
);

   assign A    = x ^ y ^ cin;
   assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, WIDTH cycles per add, LSB first.
// Sum bits enter from the MSB side so the result is aligned after WIDTH shifts.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_sum;
   logic             fa_cout;

   fulladder u_fa (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .cin  (carry_q),
      .A    (fa_sum),
      .cout (fa_cout)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      carry_d     = carry_q;
      cout_d      = cout_q;
      out_valid_d = out_valid_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            carry_d = fa_cout;
            cout_d  = fa_cout;
            sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            // Exit on WIDTH-1 so a 1-bit build never needs the counter to wrap
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         carry_q     <= 1'b0;
         cout_q      <= 1'b0;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         carry_q     <= carry_d;
         cout_q      <= cout_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit and a 1-bit instance on one clock.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;
   logic       iv8, iv1;
   logic       out_ready;
   logic [7:0] a_in, b_in;
   logic       cin_in;

   logic       rdy8, ov8, co8, busy8;
   logic [7:0] s8;
   logic       rdy1, ov1, co1, busy1;
   logic [0:0] s1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv8),
      .in_ready  (rdy8),
      .a         (a_in),
      .b         (b_in),
      .cin       (cin_in),
      .out_valid (ov8),
      .out_ready (out_ready),
      .sum       (s8),
      .cout      (co8),
      .busy      (busy8)
   );

   serial_adder #(.WIDTH(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv1),
      .in_ready  (rdy1),
      .a         (a_in[0:0]),
      .b         (b_in[0:0]),
      .cin       (cin_in),
      .out_valid (ov1),
      .out_ready (out_ready),
      .sum       (s1),
      .cout      (co1),
      .busy      (busy1)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic f_ov(input bit w1);
      return w1 ? ov1 : ov8;
   endfunction

   function automatic logic f_busy(input bit w1);
      return w1 ? busy1 : busy8;
   endfunction

   function automatic logic f_rdy(input bit w1);
      return w1 ? rdy1 : rdy8;
   endfunction

   function automatic logic [7:0] f_sum(input bit w1);
      return w1 ? {7'd0, s1} : s8;
   endfunction

   function automatic logic f_cout(input bit w1);
      return w1 ? co1 : co8;
   endfunction

   // Start one add and wait for out_valid; lat counts edges incl. the accept edge
   task automatic run_op(input bit w1, input logic [7:0] av,
                         input logic [7:0] bv, input logic cv,
                         output int lat, output int bcnt);
      @(negedge clk);
      a_in   = av;
      b_in   = bv;
      cin_in = cv;
      if (w1) iv1 = 1'b1;
      else    iv8 = 1'b1;
      lat  = 0;
      bcnt = 0;
      while (1) begin
         @(negedge clk);
         iv1 = 1'b0;
         iv8 = 1'b0;
         lat++;
         if (f_busy(w1)) bcnt++;
         if (f_ov(w1) || lat >= 40) break;
      end
   endtask

   task automatic pop(input bit w1);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_after_pop", 32'(f_rdy(w1)), 32'd1);
      check("out_valid_after_pop", 32'(f_ov(w1)), 32'd0);
   endtask

   task automatic add_chk(input string tag, input bit w1,
                          input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [7:0] es,
                          input logic ec);
      int lat, bcnt;
      run_op(w1, av, bv, cv, lat, bcnt);
      check({tag, "_lat"}, 32'(lat), w1 ? 32'd2 : 32'd9);
      check({tag, "_busy"}, 32'(bcnt), w1 ? 32'd1 : 32'd8);
      check({tag, "_sum"}, 32'(f_sum(w1)), 32'(es));
      check({tag, "_cout"}, 32'(f_cout(w1)), 32'(ec));
      pop(w1);
   endtask

   initial begin
      logic [8:0] m;
      logic [1:0] m1;
      logic [7:0] ra, rb;
      logic       rc;
      rst       = 1'b1;
      iv8       = 1'b0;
      iv1       = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      cin_in    = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(rdy8), 32'd1);
      check("rst_out_valid", 32'(ov8), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_sum", 32'(s8), 32'd0);
      check("rst_cout", 32'(co8), 32'd0);
      check("rst_w1_in_ready", 32'(rdy1), 32'd1);
      rst = 1'b0;

      add_chk("zero", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
      add_chk("ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      add_chk("a5_5a_c", 1'b0, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

      // Backpressure in DONE with in_valid toggling and new operands
      begin
         int lat, bcnt;
         run_op(1'b0, 8'h3C, 8'h0F, 1'b0, lat, bcnt);
         check("3c_0f_sum", 32'(s8), 32'h4B);
         check("3c_0f_cout", 32'(co8), 32'd0);
         for (int i = 0; i < 5; i++) begin
            iv8  = ~iv8;
            a_in = 8'(i * 37 + 1);
            b_in = 8'(i * 11 + 3);
            @(negedge clk);
            check("bp_sum", 32'(s8), 32'h4B);
            check("bp_cout", 32'(co8), 32'd0);
            check("bp_in_ready", 32'(rdy8), 32'd0);
            check("bp_out_valid", 32'(ov8), 32'd1);
            check("bp_busy", 32'(busy8), 32'd0);
         end
         // in_valid with out_ready in DONE: only the return to IDLE happens
         iv8       = 1'b1;
         out_ready = 1'b1;
         @(negedge clk);
         iv8       = 1'b0;
         out_ready = 1'b0;
         check("pop_iv_in_ready", 32'(rdy8), 32'd1);
         check("pop_iv_busy", 32'(busy8), 32'd0);
         check("idle_keep_sum", 32'(s8), 32'h4B);
         @(negedge clk);
         check("idle_stays", 32'(rdy8), 32'd1);
      end

      // Reset and in_valid together: reset wins
      rst = 1'b1;
      iv8 = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      iv8 = 1'b0;
      check("rst_iv_busy", 32'(busy8), 32'd0);
      check("rst_iv_in_ready", 32'(rdy8), 32'd1);
      check("rst_iv_sum", 32'(s8), 32'd0);

      // Reset in the middle of a run
      @(negedge clk);
      a_in   = 8'hFF;
      b_in   = 8'hFF;
      cin_in = 1'b0;
      iv8    = 1'b1;
      @(negedge clk);
      iv8 = 1'b0;
      repeat (3) @(negedge clk);
      check("midrun_busy", 32'(busy8), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrun_rst_in_ready", 32'(rdy8), 32'd1);
      check("midrun_rst_busy", 32'(busy8), 32'd0);
      check("midrun_rst_out_valid", 32'(ov8), 32'd0);
      check("midrun_rst_sum", 32'(s8), 32'd0);
      check("midrun_rst_cout", 32'(co8), 32'd0);
      add_chk("after_rst", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

      for (int i = 0; i < 12; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         m  = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         add_chk("rand8", 1'b0, ra, rb, rc, m[7:0], m[8]);
      end

      add_chk("w1_111", 1'b1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1);
      for (int i = 0; i < 8; i++) begin
         m1 = 2'(i[0]) + 2'(i[1]) + 2'(i[2]);
         add_chk("w1_sweep", 1'b1, {7'd0, i[0]}, {7'd0, i[1]}, i[2],
                 {7'd0, m1[0]}, m1[1]);
      end
      for (int i = 0; i < 8; i++) begin
         ra = 8'($urandom_range(1, 0));
         rb = 8'($urandom_range(1, 0));
         rc = 1'($urandom);
         m1 = 2'(ra[0]) + 2'(rb[0]) + 2'(rc);
         add_chk("w1_rand", 1'b1, ra, rb, rc, {7'd0, m1[0]}, m1[1]);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
